// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command sequencer for the signed accumulator ALU with iterative shift-add MUL
// Optional SAT_ARITH_EN: saturating ADD/SUB/NEG/MUL instead of wrap-around.
module alu_seq_ctrl #(
    parameter int WIDTH = 11,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_opnd,
    output logic [WIDTH-1:0] acc,
    output logic             done,
    output logic             illegal,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_LOAD = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(4);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6);
    localparam logic [OPW-1:0] OP_OR   = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8);

`ifdef SAT_ARITH_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_q;
    logic             z_q, n_q, v_q, done_q, ill_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    psum_q, psum_d, mul_addend;

    logic [WIDTH-1:0] ex_res, sum, diff, neg;
    logic             ex_v, ex_wr, ex_ill;
    logic [WIDTH-1:0] mul_res;
    logic             mul_v;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        cmd_ready = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                accept  = 1'b1;
                state_d = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: state_d = S_IDLE;
            S_MUL:  if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle result; overflow uses operand/result sign bits.
    always_comb begin
        sum    = acc_q + opnd_q;
        diff   = acc_q - opnd_q;
        neg    = '0 - acc_q;
        ex_res = acc_q;
        ex_v   = 1'b0;
        ex_wr  = 1'b1;
        ex_ill = 1'b0;
        case (op_q)
            OP_NOP:  ex_wr = 1'b0;
            OP_LOAD: ex_res = opnd_q;
            OP_ADD: begin
                ex_res = sum;
                ex_v   = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
                ex_res = diff;
                ex_v   = (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_NOT:  ex_res = ~acc_q;
            OP_NEG: begin
                ex_res = neg;
                ex_v   = (acc_q == MINV);
            end
            OP_AND:  ex_res = acc_q & opnd_q;
            OP_OR:   ex_res = acc_q | opnd_q;
            OP_MUL:  ex_wr = 1'b0;
            default: begin
                ex_wr  = 1'b0;
                ex_ill = 1'b1;
            end
        endcase
`ifdef SAT_ARITH_EN
        // An overflowed result carries the wrong sign, so clamp opposite to it.
        if (ex_v) ex_res = ex_res[WIDTH-1] ? MAXV : MINV;
`endif
    end

`ifdef SAT_ARITH_EN
    logic [WIDTH:0] mul_hi;
    logic           mul_fits;
    always_comb begin
        mul_addend = {{WIDTH{acc_q[WIDTH-1]}}, acc_q} << cnt_q;
        psum_d     = psum_q;
        // The multiplier's top bit has negative weight in two's complement.
        if (opnd_q[cnt_q])
            psum_d = (cnt_q == CNT_LAST) ? psum_q - mul_addend : psum_q + mul_addend;
        mul_hi   = psum_q[PW-1:WIDTH-1];
        mul_fits = (&mul_hi) | ~(|mul_hi);
        mul_res  = mul_fits ? psum_q[WIDTH-1:0] : (psum_q[PW-1] ? MINV : MAXV);
        mul_v    = ~mul_fits;
    end
`else
    always_comb begin
        mul_addend = acc_q << cnt_q;
        psum_d     = opnd_q[cnt_q] ? psum_q + mul_addend : psum_q;
        mul_res    = psum_q;
        mul_v      = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            z_q    <= 1'b1;
            n_q    <= 1'b0;
            v_q    <= 1'b0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            cnt_q  <= '0;
            psum_q <= '0;
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            if (accept) begin
                op_q   <= cmd_op;
                opnd_q <= cmd_opnd;
                cnt_q  <= '0;
                psum_q <= '0;
            end
            case (state_q)
                S_EXEC: begin
                    done_q <= 1'b1;
                    ill_q  <= ex_ill;
                    if (ex_wr) begin
                        acc_q <= ex_res;
                        z_q   <= (ex_res == '0);
                        n_q   <= ex_res[WIDTH-1];
                        v_q   <= ex_v;
                    end
                end
                S_MUL: begin
                    psum_q <= psum_d;
                    cnt_q  <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    acc_q  <= mul_res;
                    z_q    <= (mul_res == '0);
                    n_q    <= mul_res[WIDTH-1];
                    v_q    <= mul_v;
                end
                default: ;
            endcase
        end
    end

    assign acc     = acc_q;
    assign done    = done_q;
    assign illegal = ill_q;
    assign flag_z  = z_q;
    assign flag_n  = n_q;
    assign flag_v  = v_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed and randomized bench for alu_seq_ctrl against an integer reference model
module tb_alu_seq_ctrl;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [W-1:0] cmd_opnd = '0;
    logic [W-1:0] acc;
    logic         done, illegal, flag_z, flag_n, flag_v;

    int n_pass = 0;
    int n_checks = 0;
    int m_acc = 0;
    bit m_v = 1'b0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_opnd(cmd_opnd), .acc(acc), .done(done),
        .illegal(illegal), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int wrap(input int r);
        int w;
        w = r & 2047;
        if (w >= 1024) w -= 2048;
        return w;
    endfunction

    // Reference: exact integer result, range test for overflow, then wrap or clamp.
    task automatic model(input int op, input int b, output bit wr, output bit ill);
        int a;
        int r;
        bit ovf;
        a = m_acc; r = 0; wr = 1'b1; ill = 1'b0;
        case (op)
            0: wr = 1'b0;
            1: r = b;
            2: r = a + b;
            3: r = a - b;
            4: r = -a - 1;
            5: r = -a;
            6: r = a & b;
            7: r = a | b;
            8: r = a * b;
            default: begin wr = 1'b0; ill = 1'b1; end
        endcase
        if (wr) begin
            ovf = (r > 1023) || (r < -1024);
`ifdef SAT_ARITH_EN
            if (ovf) r = (r > 0) ? 1023 : -1024;
            m_v = ovf && (op == 2 || op == 3 || op == 5 || op == 8);
`else
            m_v = ovf && (op == 2 || op == 3 || op == 5);
`endif
            m_acc = wrap(r);
        end
    endtask

    task automatic send(input int op, input int b, input bit hold);
        bit wr, ill, ready_ok;
        int k, exp_lat;
        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        check("ready_before_send", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op[3:0]; cmd_opnd = b[W-1:0];
        @(posedge clk); #1;
        if (hold) begin cmd_op = 4'd1; cmd_opnd = '0; end
        else cmd_valid = 1'b0;
        model(op, b, wr, ill);
        exp_lat = (op == 8) ? W + 1 : 1;
        @(negedge clk);
        k = 0; ready_ok = 1'b1;
        while (!done && k < 40) begin
            if (cmd_ready) ready_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        check($sformatf("latency op%0d", op), 32'(k), 32'(exp_lat));
        check("ready_low_busy", 32'(ready_ok), 32'd1);
        check("ready_at_done", 32'(cmd_ready), 32'd1);
        check($sformatf("illegal op%0d", op), 32'(illegal), 32'(ill));
        check($sformatf("acc op%0d opnd%0d", op, b), 32'(acc), 32'(m_acc & 2047));
        check("flag_z", 32'(flag_z), 32'(m_acc == 0));
        check("flag_n", 32'(flag_n), 32'(m_acc < 0));
        check("flag_v", 32'(flag_v), 32'(m_v));
        @(negedge clk);
        check("done_one_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        bit saw_done;
        int r;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_z", 32'(flag_z), 32'd1);
        check("rst_n", 32'(flag_n), 32'd0);
        check("rst_v", 32'(flag_v), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        send(1, 3, 1'b0);
        send(4, 0, 1'b0);
        send(1, 999, 1'b0);
        send(2, 999, 1'b0);
        send(1, -9, 1'b0);
        send(8, 111, 1'b1);
        send(1, -1024, 1'b0);
        send(5, 0, 1'b0);
        send(3, -1, 1'b0);

        send(1, 7, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_opnd = 11'd5;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mulrst_acc", 32'(acc), 32'd0);
        check("mulrst_ready", 32'(cmd_ready), 32'd1);
        check("mulrst_done", 32'(done), 32'd0);
        check("mulrst_z", 32'(flag_z), 32'd1);
        rst = 1'b0; m_acc = 0; m_v = 1'b0;
        saw_done = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("mulrst_no_done", 32'(saw_done), 32'd0);
        send(1, 55, 1'b0);
        send(12, 3, 1'b0);
        send(0, 77, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 19));
            send((r < 16) ? r : 8, int'($urandom_range(0, 2047)) - 1024, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
